vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator: horizontal and vertical counters, porch/sync phase state machines, and registered sync/blanking/strobe outputs.
- Replaces the fixed 800-count horizontal counter. Fixes end-of-line strobe alignment and adds a vertical axis, sync polarity, pixel enable and line/frame strobes.
- Drives the pixel pipeline and the VGA pins from pixel_clk.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_timing_gen_axis.sv | 66 ++++++
 rtl/vga_timing_gen.sv | 99 +++++++++
 tb/tb_vga_timing_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster-timing types, 640x480@60 defaults and boundary helpers.
// Pure declarations: no logic, no latency, no flow control.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CW       = 10;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int bp_start(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping position counter plus ACTIVE/FP/SYNC/BP phase FSM.
// Registered outputs move on the same edge as the count; step=0 holds everything.
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter int CW     = VGA_CW
) (
    input  logic          pixel_clk,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] count,
    output phase_t        phase,
    output logic          last,
    output phase_t        phase_nxt
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CW-1:0] C_LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] C_FP_M1   = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] C_SYNC_M1 = CW'(sync_start(ACTIVE, FP) - 1);
    localparam logic [CW-1:0] C_BP_M1   = CW'(bp_start(ACTIVE, FP, SYNC) - 1);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
        $error("timing_axis: every timing parameter must be at least 1");
    end
    if (TOTAL > (1 << CW)) begin : g_bad_width
        $error("timing_axis: axis total does not fit in CW bits");
    end

    logic [CW-1:0] count_nxt;

    // Phase moves on the edge that carries the count across a boundary.
    always_comb begin
        count_nxt = count;
        phase_nxt = phase;
        if (step) begin
            count_nxt = (count == C_LAST) ? '0 : count + 1'b1;
            case (phase)
                PH_ACTIVE: if (count == C_FP_M1)   phase_nxt = PH_FP;
                PH_FP:     if (count == C_SYNC_M1) phase_nxt = PH_SYNC;
                PH_SYNC:   if (count == C_BP_M1)   phase_nxt = PH_BP;
                PH_BP:     if (count == C_LAST)    phase_nxt = PH_ACTIVE;
                default:   phase_nxt = PH_BP;
            endcase
        end
    end

    // The parked reset position is not a reached end, so last starts low.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            count <= C_LAST;
            phase <= PH_BP;
            last  <= 1'b0;
        end else if (step) begin
            count <= count_nxt;
            phase <= phase_nxt;
            last  <= (count_nxt == C_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counts, phases, syncs, display enable and line/frame strobes.
// All outputs registered and aligned with the counts; ce=0 holds every output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CW         = VGA_CW
) (
    input  logic          pixel_clk,
    input  logic          reset,
    input  logic          ce,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic [1:0]    h_phase,
    output logic [1:0]    v_phase,
    output logic          display_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_end,
    output logic          frame_end
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_PRE_LAST = CW'(H_TOTAL - 2);

    phase_t h_ph;
    phase_t v_ph;
    phase_t h_ph_nxt;
    phase_t v_ph_nxt;
    logic   h_last;
    logic   v_last;
    logic   v_step;

    // Compare on h_count, not h_last, so the first edge out of reset also wraps v.
    assign v_step = ce & (h_count == H_LAST);

    timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .step      (ce),
        .count     (h_count),
        .phase     (h_ph),
        .last      (h_last),
        .phase_nxt (h_ph_nxt)
    );

    timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .step      (v_step),
        .count     (v_count),
        .phase     (v_ph),
        .last      (v_last),
        .phase_nxt (v_ph_nxt)
    );

    assign h_phase  = h_ph;
    assign v_phase  = v_ph;
    assign line_end = h_last;

    // At h = H_TOTAL-2 the vertical axis cannot step, so v_last already describes the next cycle.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            display_on <= 1'b0;
            hsync      <= ~H_SYNC_POL;
            vsync      <= ~V_SYNC_POL;
            frame_end  <= 1'b0;
        end else if (ce) begin
            display_on <= (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);
            hsync      <= (h_ph_nxt == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync      <= (v_ph_nxt == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            frame_end  <= (h_count == H_PRE_LAST) && v_last;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three timing generators (default, tiny, medium) checked every cycle against a position model.
module tb_vga_timing_gen;

    localparam int HA [3] = '{640, 4, 16};
    localparam int HF [3] = '{16, 1, 2};
    localparam int HS [3] = '{96, 1, 4};
    localparam int HB [3] = '{48, 1, 3};
    localparam int VA [3] = '{480, 2, 12};
    localparam int VF [3] = '{10, 1, 3};
    localparam int VS [3] = '{2, 1, 2};
    localparam int VB [3] = '{33, 1, 4};
    localparam int HP [3] = '{0, 1, 0};
    localparam int VP [3] = '{0, 0, 1};

    logic pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    logic reset;
    logic ce_v [3];

    logic [9:0] h0, v0;
    logic [3:0] h1, v1;
    logic [5:0] h2, v2;
    logic [1:0] hp0, vp0, hp1, vp1, hp2, vp2;
    logic       de0, hs0, vs0, le0, fe0;
    logic       de1, hs1, vs1, le1, fe1;
    logic       de2, hs2, vs2, le2, fe2;

    vga_timing_gen u_dut0 (
        .pixel_clk (pixel_clk), .reset (reset), .ce (ce_v[0]),
        .h_count (h0), .v_count (v0), .h_phase (hp0), .v_phase (vp0),
        .display_on (de0), .hsync (hs0), .vsync (vs0),
        .line_end (le0), .frame_end (fe0)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b0), .CW (4)
    ) u_dut1 (
        .pixel_clk (pixel_clk), .reset (reset), .ce (ce_v[1]),
        .h_count (h1), .v_count (v1), .h_phase (hp1), .v_phase (vp1),
        .display_on (de1), .hsync (hs1), .vsync (vs1),
        .line_end (le1), .frame_end (fe1)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_ACTIVE (12), .V_FP (3), .V_SYNC (2), .V_BP (4),
        .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b1), .CW (6)
    ) u_dut2 (
        .pixel_clk (pixel_clk), .reset (reset), .ce (ce_v[2]),
        .h_count (h2), .v_count (v2), .h_phase (hp2), .v_phase (vp2),
        .display_on (de2), .hsync (hs2), .vsync (vs2),
        .line_end (le2), .frame_end (fe2)
    );

    logic [31:0] o_h [3], o_v [3], o_hp [3], o_vp [3];
    logic [31:0] o_de [3], o_hs [3], o_vs [3], o_le [3], o_fe [3];

    always_comb begin
        o_h[0] = 32'(h0);  o_v[0] = 32'(v0);  o_hp[0] = 32'(hp0); o_vp[0] = 32'(vp0);
        o_h[1] = 32'(h1);  o_v[1] = 32'(v1);  o_hp[1] = 32'(hp1); o_vp[1] = 32'(vp1);
        o_h[2] = 32'(h2);  o_v[2] = 32'(v2);  o_hp[2] = 32'(hp2); o_vp[2] = 32'(vp2);
        o_de[0] = 32'(de0); o_hs[0] = 32'(hs0); o_vs[0] = 32'(vs0); o_le[0] = 32'(le0); o_fe[0] = 32'(fe0);
        o_de[1] = 32'(de1); o_hs[1] = 32'(hs1); o_vs[1] = 32'(vs1); o_le[1] = 32'(le1); o_fe[1] = 32'(fe1);
        o_de[2] = 32'(de2); o_hs[2] = 32'(hs2); o_vs[2] = 32'(vs2); o_le[2] = 32'(le2); o_fe[2] = 32'(fe2);
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: raster position and whether we are still parked after reset.
    int mh [3];
    int mv [3];
    bit fresh [3];

    function automatic int htot(input int c);
        return HA[c] + HF[c] + HS[c] + HB[c];
    endfunction

    function automatic int vtot(input int c);
        return VA[c] + VF[c] + VS[c] + VB[c];
    endfunction

    function automatic int phase_of(input int n, input int a, input int f, input int s);
        if (n < a) return 0;
        if (n < a + f) return 1;
        if (n < a + f + s) return 2;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            if (reset) begin
                mh[c] = htot(c) - 1;
                mv[c] = vtot(c) - 1;
                fresh[c] = 1'b1;
            end else if (ce_v[c]) begin
                fresh[c] = 1'b0;
                if (mh[c] == htot(c) - 1) begin
                    mh[c] = 0;
                    mv[c] = (mv[c] == vtot(c) - 1) ? 0 : mv[c] + 1;
                end else begin
                    mh[c] = mh[c] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            int  hp, vp;
            bit  le;
            hp = phase_of(mh[c], HA[c], HF[c], HS[c]);
            vp = phase_of(mv[c], VA[c], VF[c], VS[c]);
            le = !fresh[c] && (mh[c] == htot(c) - 1);
            chk($sformatf("u%0d.h_count", c), o_h[c], 32'(mh[c]));
            chk($sformatf("u%0d.v_count", c), o_v[c], 32'(mv[c]));
            chk($sformatf("u%0d.h_phase", c), o_hp[c], 32'(hp));
            chk($sformatf("u%0d.v_phase", c), o_vp[c], 32'(vp));
            chk($sformatf("u%0d.display_on", c), o_de[c], 32'(hp == 0 && vp == 0));
            chk($sformatf("u%0d.hsync", c), o_hs[c], 32'((hp == 2) ? HP[c] : 1 - HP[c]));
            chk($sformatf("u%0d.vsync", c), o_vs[c], 32'((vp == 2) ? VP[c] : 1 - VP[c]));
            chk($sformatf("u%0d.line_end", c), o_le[c], 32'(le));
            chk($sformatf("u%0d.frame_end", c), o_fe[c], 32'(le && mv[c] == vtot(c) - 1));
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        model_step();
        @(negedge pixel_clk);
        check_all();
    endtask

    task automatic set_ce(input logic val);
        for (int c = 0; c < 3; c++) ce_v[c] = val;
    endtask

    initial begin
        int hs_low, le_cnt, hold_bad, n, fe_cnt, hs_hi, vs_lo, vs_hi;
        logic [31:0] prev_h;

        reset = 1'b1;
        set_ce(1'b1);
        repeat (3) tick();
        chk("rst_h_count", o_h[0], 32'd799);
        chk("rst_v_count", o_v[0], 32'd524);
        chk("rst_display_on", o_de[0], 32'd0);
        chk("rst_hsync", o_hs[0], 32'd1);
        chk("rst_vsync", o_vs[0], 32'd1);
        chk("rst_line_end", o_le[0], 32'd0);
        chk("rst_frame_end", o_fe[0], 32'd0);

        reset = 1'b0;
        tick();
        chk("first_h", o_h[0], 32'd0);
        chk("first_v", o_v[0], 32'd0);
        chk("first_display_on", o_de[0], 32'd1);

        hs_low = 0;
        le_cnt = 0;
        repeat (800) begin
            tick();
            if (o_hs[0] == 32'd0) hs_low++;
            if (o_le[0] == 32'd1) le_cnt++;
        end
        chk("line_hsync_low_cycles", 32'(hs_low), 32'd96);
        chk("line_end_pulses", 32'(le_cnt), 32'd1);
        chk("line_wrap_h", o_h[0], 32'd0);
        chk("line_wrap_v", o_v[0], 32'd1);

        le_cnt = 0;
        hold_bad = 0;
        for (int i = 0; i < 3200; i++) begin
            set_ce((i % 2) == 0);
            prev_h = o_h[0];
            tick();
            if ((i % 2) == 1 && o_h[0] !== prev_h) hold_bad++;
            if (o_le[0] == 32'd1) le_cnt++;
        end
        chk("toggle_line_end_cycles", 32'(le_cnt), 32'd4);
        chk("toggle_hold_violations", 32'(hold_bad), 32'd0);
        chk("toggle_end_h", o_h[0], 32'd0);
        chk("toggle_end_v", o_v[0], 32'd3);

        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) ce_v[c] = ($urandom_range(3) != 0);
            tick();
        end

        set_ce(1'b1);
        n = 0;
        while (o_h[0] !== 32'd300 && n < 1000) begin
            tick();
            n++;
        end
        chk("reach_h300", o_h[0], 32'd300);
        set_ce(1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_h", o_h[0], 32'd799);
        chk("mid_rst_v", o_v[0], 32'd524);
        chk("mid_rst_hsync", o_hs[0], 32'd1);
        reset = 1'b0;
        tick();
        chk("post_rst_hold_h", o_h[0], 32'd799);
        chk("post_rst_hold_line_end", o_le[0], 32'd0);
        set_ce(1'b1);
        tick();
        chk("post_rst_first_h", o_h[0], 32'd0);
        chk("post_rst_first_v", o_v[0], 32'd0);
        chk("post_rst_display_on", o_de[0], 32'd1);

        fe_cnt = 0;
        hs_hi = 0;
        vs_lo = 0;
        repeat (35) begin
            tick();
            if (o_fe[1] == 32'd1) fe_cnt++;
            if (o_hs[1] == 32'd1) hs_hi++;
            if (o_vs[1] == 32'd0) vs_lo++;
        end
        chk("small_frame_end_pulses", 32'(fe_cnt), 32'd1);
        chk("small_hsync_high_cycles", 32'(hs_hi), 32'd5);
        chk("small_vsync_low_cycles", 32'(vs_lo), 32'd7);
        chk("small_wrap_h", o_h[1], 32'd0);
        chk("small_wrap_v", o_v[1], 32'd0);
        chk("small_wrap_frame_end", o_fe[1], 32'd0);

        fe_cnt = 0;
        vs_hi = 0;
        repeat (525) begin
            tick();
            if (o_fe[2] == 32'd1) fe_cnt++;
            if (o_vs[2] == 32'd1) vs_hi++;
        end
        chk("mid_frame_end_pulses", 32'(fe_cnt), 32'd1);
        chk("mid_vsync_high_cycles", 32'(vs_hi), 32'd50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
